// File: rtl/vga_sprite_engine.sv
// vga_sprite_engine: VGA timing generator with one scaled, animated ROM sprite.
// Three-stage pipeline: position -> ROM address -> ROM data -> pixel.
module vga_sprite_engine #(
    parameter int H_ACTIVE      = 640,
    parameter int H_FP          = 16,
    parameter int H_SYNC        = 96,
    parameter int H_BP          = 48,
    parameter int V_ACTIVE      = 480,
    parameter int V_FP          = 10,
    parameter int V_SYNC        = 2,
    parameter int V_BP          = 33,
    parameter bit HSYNC_POL     = 1'b0,
    parameter bit VSYNC_POL     = 1'b0,
    parameter int COLOR_BITS    = 2,
    parameter int SPR_W         = 34,
    parameter int SPR_H         = 22,
    parameter int SCALE_BITS    = 3,
    parameter int SPR_FRAMES    = 2,
    parameter int ANIM_DIV_BITS = 4,
    parameter logic [3*COLOR_BITS-1:0] BG_COLOR = 6'b000111,
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int HW      = $clog2(H_TOTAL),
    localparam int VW      = $clog2(V_TOTAL),
    localparam int TXW     = $clog2(SPR_W),
    localparam int TYW     = $clog2(SPR_H),
    localparam int AW      = $clog2(SPR_FRAMES),
    localparam int AD_W    = AW + TYW + TXW,
    localparam int CW      = 3 * COLOR_BITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [HW-1:0]         sprite_x,
    input  logic [VW-1:0]         sprite_y,
    output logic [AD_W-1:0]       rom_addr,
    input  logic [CW:0]           rom_data,
    output logic                  vga_hsync,
    output logic                  vga_vsync,
    output logic [COLOR_BITS-1:0] vga_r,
    output logic [COLOR_BITS-1:0] vga_g,
    output logic [COLOR_BITS-1:0] vga_b,
    output logic                  vga_de,
    output logic                  frame_start
);

    localparam int FCW = ANIM_DIV_BITS + AW;

    typedef struct packed {
        logic de;
        logic hs;
        logic vs;
        logic fs;
        logic spr;
    } ctl_t;

    logic [HW-1:0]  h;
    logic [VW-1:0]  v;
    logic           h_last;
    logic           v_last;
    logic           origin;
    logic [HW-1:0]  lat_x;
    logic [VW-1:0]  lat_y;
    logic [FCW-1:0] frame_cnt;
    logic [AW-1:0]  anim;

    assign h_last = h == HW'(H_TOTAL - 1);
    assign v_last = v == VW'(V_TOTAL - 1);
    assign origin = (h == '0) && (v == '0);
    assign anim   = frame_cnt[FCW-1 -: AW];

    always_ff @(posedge clk) begin
        if (rst) begin
            h <= '0;
            v <= '0;
        end else if (h_last) begin
            h <= '0;
            v <= v_last ? '0 : v + 1'b1;
        end else begin
            h <= h + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lat_x     <= '0;
            lat_y     <= '0;
            frame_cnt <= '0;
        end else begin
            if (origin) begin
                lat_x <= sprite_x;
                lat_y <= sprite_y;
            end
            if (h_last && v_last) begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    // Pixel (0,0) uses the live position, since it is being latched this cycle.
    logic [HW:0]    hx, x0, dx;
    logic [VW:0]    vx, y0, dy;
    logic           in_x, in_y;
    logic           hs_act, vs_act, de;
    logic [TXW-1:0] tx;
    logic [TYW-1:0] ty;

    assign hx = {1'b0, h};
    assign vx = {1'b0, v};
    assign x0 = {1'b0, origin ? sprite_x : lat_x};
    assign y0 = {1'b0, origin ? sprite_y : lat_y};
    assign dx = hx - x0;
    assign dy = vx - y0;

    assign in_x = (hx >= x0) && (hx < x0 + (HW+1)'(SPR_W << SCALE_BITS));
    assign in_y = (vx >= y0) && (vx < y0 + (VW+1)'(SPR_H << SCALE_BITS));
    assign tx   = TXW'(dx >> SCALE_BITS);
    assign ty   = TYW'(dy >> SCALE_BITS);

    assign hs_act = (hx >= (HW+1)'(H_ACTIVE + H_FP))
                 && (hx < (HW+1)'(H_ACTIVE + H_FP + H_SYNC));
    assign vs_act = (vx >= (VW+1)'(V_ACTIVE + V_FP))
                 && (vx < (VW+1)'(V_ACTIVE + V_FP + V_SYNC));
    assign de     = (hx < (HW+1)'(H_ACTIVE)) && (vx < (VW+1)'(V_ACTIVE));

    ctl_t c0, s1, s2;

    assign c0 = {de, hs_act, vs_act, origin, in_x && in_y};

    always_ff @(posedge clk) begin
        if (rst) begin
            s1       <= '0;
            s2       <= '0;
            rom_addr <= '0;
        end else begin
            s1 <= c0;
            s2 <= s1;
            if (c0.spr) begin
                rom_addr <= {anim, ty, tx};
            end
        end
    end

    logic [CW-1:0] pix;

    always_comb begin
        pix = BG_COLOR;
        if (!s2.de) begin
            pix = '0;
        end else if (s2.spr && rom_data[CW]) begin
            pix = rom_data[CW-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vga_hsync   <= ~HSYNC_POL;
            vga_vsync   <= ~VSYNC_POL;
            vga_de      <= 1'b0;
            frame_start <= 1'b0;
            vga_r       <= '0;
            vga_g       <= '0;
            vga_b       <= '0;
        end else begin
            vga_hsync   <= s2.hs ? HSYNC_POL : ~HSYNC_POL;
            vga_vsync   <= s2.vs ? VSYNC_POL : ~VSYNC_POL;
            vga_de      <= s2.de;
            frame_start <= s2.fs;
            vga_r       <= pix[CW-1 -: COLOR_BITS];
            vga_g       <= pix[2*COLOR_BITS-1 -: COLOR_BITS];
            vga_b       <= pix[COLOR_BITS-1:0];
        end
    end

endmodule

// File: doc/vga_sprite_engine.md
VGA_SPRITE_ENGINE -- requirements
Module: vga_sprite_engine

Interface
REQ-001 SHALL have parameters (name, default, meaning):
  H_ACTIVE 640 visible px; H_FP 16; H_SYNC 96; H_BP 48 (px clocks)
  V_ACTIVE 480 visible lines; V_FP 10; V_SYNC 2; V_BP 33 (lines)
  HSYNC_POL 0, VSYNC_POL 0: sync active level
  COLOR_BITS 2: bits per channel
  SPR_W 34, SPR_H 22: sprite size in texels
  SCALE_BITS 3: texel = 2**SCALE_BITS px square
  SPR_FRAMES 2: animation frames in ROM (power of 2)
  ANIM_DIV_BITS 4: frames per animation step = 2**ANIM_DIV_BITS
  BG_COLOR 6'b000111: active-area background {r,g,b}
REQ-002 SHALL have ports (name, direction, width, meaning):
  clk  in  1  pixel clock
  rst  in  1  synchronous, active-high reset
  sprite_x  in  clog2(H total)  sprite left edge, px
  sprite_y  in  clog2(V total)  sprite top edge, lines
  rom_addr  out  clog2(SPR_FRAMES)+clog2(SPR_H)+clog2(SPR_W)  {anim, ty, tx}
  rom_data  in  1+3*COLOR_BITS  {opaque, r, g, b}; 1-cycle read latency
  vga_hsync, vga_vsync  out  1  syncs
  vga_r, vga_g, vga_b  out  COLOR_BITS each
  vga_de  out  1  active-video flag
  frame_start  out  1  one-cycle pulse
REQ-003 One clock, clk; reset is synchronous and active-high, port rst.

Function
REQ-004 h counter SHALL count 0..H_ACTIVE+H_FP+H_SYNC+H_BP-1 and wrap to 0; v SHALL increment on each h wrap, wrapping at V total-1.
REQ-005 Sync SHALL be at active level for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC) and v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), else inactive.
REQ-006 vga_de SHALL be 1 iff h<H_ACTIVE and v<V_ACTIVE.
REQ-007 On the cycle counters become (0,0), sprite_x/sprite_y SHALL be latched; mid-frame input changes SHALL have no effect until the next (0,0).
REQ-008 frame_cnt (ANIM_DIV_BITS+clog2(SPR_FRAMES) bits) SHALL increment at each (0,0), wrapping freely; anim = frame_cnt >> ANIM_DIV_BITS.
REQ-009 In-sprite iff latched_x <= h < latched_x+SPR_W<<SCALE_BITS and same for v; comparison SHALL use widths one bit wider than the counters (no overflow wrap).
REQ-010 tx=(h-latched_x)>>SCALE_BITS, ty=(v-latched_y)>>SCALE_BITS; rom_addr SHALL be registered, valid one cycle after the counter position.
REQ-011 Pipeline: counter position at cycle n -> rom_addr cycle n+1 -> rom_data cycle n+2 -> outputs at cycle n+3; syncs, de and frame_start SHALL be delayed by the same 3 cycles.
REQ-012 Color select: de=0 -> 0; in-sprite and opaque=1 -> rom_data rgb; otherwise BG_COLOR.
REQ-013 Sprite parts beyond H_ACTIVE/V_ACTIVE SHALL NOT be drawn; blanking has priority.
REQ-014 frame_start SHALL pulse for exactly one output cycle aligned to pixel (0,0).
REQ-015 rom_addr outside sprite SHALL hold its last value (no X, no spurious toggling requirement beyond that).

Reset
REQ-016 While rst=1 at a clk edge: h=v=0, frame_cnt=0, latched pos=0, pipeline cleared, rgb=0, vga_de=0, frame_start=0, syncs inactive (~POL), rom_addr=0.
REQ-017 Reset mid-frame SHALL abort the frame; first cycle after release counters start at (0,0) and pos is latched that cycle.
REQ-018 After release, first valid outputs appear 3 cycles later; outputs before then SHALL stay at reset values.

Verification
REQ-019 Defaults, rst 2 cycles: hsync low 96 clocks per 800-clock line, vsync low 2 lines per 525, de high 640x480.
REQ-020 sprite_x=128,y=128, ROM all opaque red 6'b110000: px (128..399,128..303) red, (127,128) BG 000111; rom_addr at (136,128) tx=1,ty=0.
REQ-021 ROM opaque=0 everywhere: whole active area BG, blanking 0.
REQ-022 sprite_x=600: columns 600..639 sprite, 640+ black; no wrap to x=0.
REQ-023 Change sprite_x mid-frame 128->200: current frame unchanged, next frame at 200.
REQ-024 anim field in rom_addr 0 for frames 0..15, 1 for 16..31, 0 at 32; rst at v=200 -> outputs 0 for 3 cycles, then restart at (0,0) with frame_cnt=0.
